// File: rtl/hazard_pkg.sv
// hazard_pkg: shared widths, counter types and saturating decrement for the hazard scoreboard
package hazard_pkg;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_MAX_LAT = 7;
  localparam int REG_AW = $clog2(DEF_NUM_REGS);
  localparam int LAT_W = $clog2(DEF_MAX_LAT + 1);
  typedef logic [LAT_W-1:0] lat_t;
  typedef lat_t cnt_arr_t [DEF_NUM_REGS];
  function automatic lat_t sat_dec(input lat_t x);
    return (x == '0) ? x : x - lat_t'(1);
  endfunction
endpackage

// File: rtl/hazard_sb_entry.sv
// hazard_sb_entry: pending-write countdown for one architectural register
module hazard_sb_entry
  import hazard_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic hold_i,
  input  logic set_i,
  input  logic restore_i,
  input  lat_t set_val_i,
  input  lat_t restore_val_i,
  output lat_t cnt_o
);
  lat_t cnt_q, cnt_d;
  // Freeze beats rollback beats a new issue beats the normal countdown
  always_comb cnt_d = hold_i ? cnt_q : restore_i ? restore_val_i : set_i ? set_val_i : sat_dec(cnt_q);
  // Counter register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register RAW/WAW stall scoreboard for ID; HAZARD_PERF_EN adds a stall-cycle counter
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int MAX_LAT = DEF_MAX_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_wen,
  input  lat_t              id_lat,
  input  logic              mem_freeze,
  input  logic              flush_ex,
  output logic              stall,
  output logic              stall_raw,
  output logic              stall_waw,
  output logic              busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt
`endif
);
  cnt_arr_t          cnt_w;
  logic              issue, track, rollback;
  logic              last_valid_q, last_valid_d;
  logic [REG_AW-1:0] last_rd_q, last_rd_d;
  lat_t              last_prev_q, last_prev_d;
  assign cnt_w[0] = '0;
  genvar g;
  for (g = 1; g < NUM_REGS; g++) begin : g_entry
    hazard_sb_entry u_entry (
      .clk          (clk),
      .rst_n        (rst_n),
      .hold_i       (mem_freeze),
      .set_i        (track && id_rd == REG_AW'(g)),
      .restore_i    (rollback && last_rd_q == REG_AW'(g)),
      .set_val_i    (id_lat),
      .restore_val_i(sat_dec(last_prev_q)),
      .cnt_o        (cnt_w[g])
    );
  end
  // Hazard compare against the registered counters; x0 reads as never pending
  always_comb begin
    stall_raw = id_valid && ((id_rs1_used && id_rs1 != '0 && cnt_w[id_rs1] != '0) ||
                             (id_rs2_used && id_rs2 != '0 && cnt_w[id_rs2] != '0));
    stall_waw = id_valid && id_rd_wen && id_rd != '0 && cnt_w[id_rd] > id_lat;
    stall = stall_raw || stall_waw;
    issue = id_valid && !stall && !mem_freeze && !flush_ex;
    track = issue && id_rd_wen && id_rd != '0 && id_lat != '0;
    rollback = !mem_freeze && flush_ex && last_valid_q;
    busy = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) busy = busy | (cnt_w[r] != '0);
  end
  // Remember the last tracked issue so a flush in EX can undo its entry
  always_comb begin
    last_valid_d = mem_freeze ? last_valid_q : track;
    last_rd_d = track ? id_rd : last_rd_q;
    last_prev_d = track ? cnt_w[id_rd] : last_prev_q;
  end
  // Rollback bookkeeping registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_valid_q <= 1'b0;
      last_rd_q <= '0;
      last_prev_q <= '0;
    end else begin
      last_valid_q <= last_valid_d;
      last_rd_q <= last_rd_d;
      last_prev_q <= last_prev_d;
    end
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_q, perf_d;
  // Count cycles lost to hazards, not to memory wait; saturate instead of wrapping
  always_comb perf_d = (stall && !mem_freeze && perf_q != '1) ? perf_q + 32'd1 : perf_q;
  // Stall counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) perf_q <= '0;
    else perf_q <= perf_d;
  assign perf_stall_cnt = perf_q;
`endif
  a_lat_legal: assert property (@(posedge clk) disable iff (!rst_n)
    id_valid |-> {1'b0, id_lat} <= (LAT_W + 1)'(MAX_LAT));
endmodule
